// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Holds the PC, issues reads to instruction
// memory, buffers returned words in a small prefetch queue tagged with their PC
// and presents the queue head to decode over a valid/ready handshake.
`timescale 1ns/1ps

module fetch_unit #(
  parameter int                    WORD_SIZE   = 19,
  parameter int                    ADDR_WIDTH  = 19,
  parameter int                    QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic                             redirect_valid,
  input  logic [ADDR_WIDTH-1:0]            redirect_addr,
  output logic                             im_rd_en,
  output logic [ADDR_WIDTH-1:0]            im_addr,
  input  logic [WORD_SIZE-1:0]             im_instr,
  output logic                             instr_valid,
  input  logic                             instr_ready,
  output logic [WORD_SIZE-1:0]             instr_data,
  output logic [ADDR_WIDTH-1:0]            instr_pc,
  output logic [$clog2(QUEUE_DEPTH):0]     queue_count
);

  localparam int PW  = $clog2(QUEUE_DEPTH);
  localparam int CW  = PW + 1;
  localparam int CW1 = CW + 1;

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] tag_q, tag_d;
  logic                  inflight_q, inflight_d;
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [WORD_SIZE-1:0]  qdata_q [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] qpc_q   [QUEUE_DEPTH];

  logic                  issue;
  logic                  push;
  logic                  pop;
  logic [CW:0]           used_now;
  logic [CW:0]           used_next;

  // Handshake decisions: credit counts queued words plus the one in flight, and a redirect suppresses issue, response capture and pop.
  always_comb begin
    used_now = {1'b0, count_q} + CW1'(inflight_q);
    issue    = en & (state_q != IDLE) & ~redirect_valid & (used_now < CW1'(QUEUE_DEPTH));
    push     = inflight_q & ~redirect_valid;
    pop      = (count_q != '0) & instr_ready & ~redirect_valid;
  end

  // Next-state computation for PC, in-flight tracking, queue pointers, occupancy and fetch state.
  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = issue;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    state_d    = state_q;
    if (redirect_valid) begin
      pc_d    = redirect_addr;
      count_d = '0;
      head_d  = tail_q;
    end else begin
      if (issue) begin
        pc_d  = pc_q + 1'b1;
        tag_d = pc_q;
      end
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
    used_next = {1'b0, count_d} + CW1'(inflight_d);
    if (!en)                              state_d = IDLE;
    else if (state_q == IDLE)             state_d = RUN;
    else if (used_next >= CW1'(QUEUE_DEPTH)) state_d = STALL;
    else                                  state_d = RUN;
  end

  // State registers and prefetch queue storage; reset discards any pending memory response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        qdata_q[i] <= '0;
        qpc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      if (push) begin
        qdata_q[tail_q] <= im_instr;
        qpc_q[tail_q]   <= tag_q;
      end
    end
  end

  assign im_rd_en    = issue;
  assign im_addr     = pc_q;
  assign instr_valid = (count_q != '0);
  assign instr_data  = qdata_q[head_q];
  assign instr_pc    = qpc_q[head_q];
  assign queue_count = count_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q == CW'(QUEUE_DEPTH))));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: drives fetch_unit with a behavioural instruction memory and
// checks the delivered instruction stream against program order since the last
// reset or redirect.
`timescale 1ns/1ps

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        redirect_valid;
  logic [18:0] redirect_addr;
  logic        im_rd_en;
  logic [18:0] im_addr;
  logic [18:0] im_instr = '0;
  logic        instr_valid;
  logic        instr_ready;
  logic [18:0] instr_data;
  logic [18:0] instr_pc;
  logic [2:0]  queue_count;

  int          total = 0;
  int          bad   = 0;
  logic [18:0] exp_pc;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .im_rd_en(im_rd_en), .im_addr(im_addr), .im_instr(im_instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  // Program image: four fixed words at 0..3, a scrambled pattern elsewhere.
  function automatic logic [18:0] mem_word(input logic [18:0] a);
    case (a)
      19'd0:   return 19'h12340;
      19'd1:   return 19'h0ABCD;
      19'd2:   return 19'h05678;
      19'd3:   return 19'h1EFF0;
      default: return (a * 19'd2731) ^ 19'h2A5A5;
    endcase
  endfunction

  // Synchronous-read instruction memory: data appears the cycle after a request.
  always @(posedge clk) if (im_rd_en) im_instr <= mem_word(im_addr);

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; redirect_valid = 1'b0; redirect_addr = '0; instr_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total += 6;
    if (im_rd_en !== 1'b0)    begin bad++; $display("[TB] FAIL rst_rd_en: got %b want 0", im_rd_en); end
    if (im_addr !== 19'd0)    begin bad++; $display("[TB] FAIL rst_addr: got %h want 0", im_addr); end
    if (instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid: got %b want 0", instr_valid); end
    if (instr_data !== 19'd0) begin bad++; $display("[TB] FAIL rst_data: got %h want 0", instr_data); end
    if (instr_pc !== 19'd0)   begin bad++; $display("[TB] FAIL rst_pc: got %h want 0", instr_pc); end
    if (queue_count !== 3'd0) begin bad++; $display("[TB] FAIL rst_count: got %0d want 0", queue_count); end
    @(negedge clk);
  endtask

  task automatic test_sequential();
    logic [18:0] tbl [4];
    int first, got;
    tbl = '{19'h12340, 19'h0ABCD, 19'h05678, 19'h1EFF0};
    do_reset();
    en = 1'b1; instr_ready = 1'b1; exp_pc = '0; first = -1; got = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (i == 0) begin
        total++;
        if (im_rd_en !== 1'b0) begin bad++; $display("[TB] FAIL seq_no_early_issue: got %b want 0", im_rd_en); end
      end
      if (i == 1) begin
        total++;
        if (im_rd_en !== 1'b1 || im_addr !== 19'd0) begin
          bad++; $display("[TB] FAIL seq_first_issue: got rd=%b addr=%h want rd=1 addr=0", im_rd_en, im_addr);
        end
      end
      if (instr_valid === 1'b1 && first < 0) first = i;
      if (first >= 0) begin
        total++;
        if (instr_valid !== 1'b1) begin bad++; $display("[TB] FAIL seq_gap: cycle %0d valid=%b want 1", i, instr_valid); end
      end
      if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
        total++;
        if (instr_pc !== exp_pc || instr_data !== mem_word(exp_pc)) begin
          bad++; $display("[TB] FAIL seq_word: got pc=%h data=%h want pc=%h data=%h", instr_pc, instr_data, exp_pc, mem_word(exp_pc));
        end
        if (got < 4) begin
          total++;
          if (instr_data !== tbl[got]) begin bad++; $display("[TB] FAIL seq_table%0d: got %h want %h", got, instr_data, tbl[got]); end
        end
        got++; exp_pc++;
      end
      @(negedge clk);
    end
    total += 2;
    if (first != 3) begin bad++; $display("[TB] FAIL seq_latency: first valid at %0d want 3", first); end
    if (got != 17)  begin bad++; $display("[TB] FAIL seq_throughput: accepted %0d want 17", got); end
  endtask

  task automatic test_stall_fill();
    int issues;
    do_reset();
    en = 1'b1; instr_ready = 1'b0; issues = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (im_rd_en === 1'b1) issues++;
      @(negedge clk);
    end
    #1;
    total += 4;
    if (issues != 4)          begin bad++; $display("[TB] FAIL fill_issues: got %0d want 4", issues); end
    if (queue_count !== 3'd4) begin bad++; $display("[TB] FAIL fill_count: got %0d want 4", queue_count); end
    if (im_rd_en !== 1'b0)    begin bad++; $display("[TB] FAIL fill_rd_en: got %b want 0", im_rd_en); end
    if (instr_valid !== 1'b1 || instr_pc !== 19'd0) begin
      bad++; $display("[TB] FAIL fill_head: got valid=%b pc=%h want valid=1 pc=0", instr_valid, instr_pc);
    end
    @(negedge clk);
    instr_ready = 1'b1; exp_pc = '0;
    for (int i = 0; i < 14; i++) begin
      #1;
      total++;
      if (instr_valid !== 1'b1) begin bad++; $display("[TB] FAIL drain_gap: cycle %0d valid=%b want 1", i, instr_valid); end
      if (instr_valid === 1'b1) begin
        total++;
        if (instr_pc !== exp_pc || instr_data !== mem_word(exp_pc)) begin
          bad++; $display("[TB] FAIL drain_word: got pc=%h data=%h want pc=%h", instr_pc, instr_data, exp_pc);
        end
        exp_pc++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    int  got;
    bit  found, prev_rd;
    do_reset();
    en = 1'b1; instr_ready = 1'b0; found = 0; prev_rd = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (queue_count === 3'd3 && prev_rd) found = 1;
      else begin prev_rd = (im_rd_en === 1'b1); @(negedge clk); end
    end
    total++;
    if (!found) begin bad++; $display("[TB] FAIL redir_setup: got found=0 want 1"); end
    redirect_valid = 1'b1; redirect_addr = 19'h00100; instr_ready = 1'b1;
    #1;
    total++;
    if (im_rd_en !== 1'b0) begin bad++; $display("[TB] FAIL redir_no_issue: got %b want 0", im_rd_en); end
    @(negedge clk);
    redirect_valid = 1'b0; exp_pc = 19'h00100; got = 0;
    for (int i = 1; i < 14; i++) begin
      #1;
      if (i == 1) begin
        total++;
        if (queue_count !== 3'd0 || im_rd_en !== 1'b1 || im_addr !== 19'h00100) begin
          bad++; $display("[TB] FAIL redir_restart: got count=%0d rd=%b addr=%h want 0 1 00100", queue_count, im_rd_en, im_addr);
        end
      end
      if (i == 1 || i == 2) begin
        total++;
        if (instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL redir_early_valid: cycle R+%0d got %b want 0", i, instr_valid); end
      end
      if (i == 3) begin
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 19'h00100) begin
          bad++; $display("[TB] FAIL redir_first: got valid=%b pc=%h want 1 00100", instr_valid, instr_pc);
        end
      end
      if (instr_valid === 1'b1) begin
        total++;
        if (instr_pc !== exp_pc || instr_data !== mem_word(exp_pc)) begin
          bad++; $display("[TB] FAIL redir_word: got pc=%h want pc=%h", instr_pc, exp_pc);
        end
        exp_pc++; got++;
      end
      @(negedge clk);
    end
    total++;
    if (got != 11) begin bad++; $display("[TB] FAIL redir_count: got %0d want 11", got); end
  endtask

  task automatic test_pc_wrap();
    logic [18:0] seen [3];
    int got;
    do_reset();
    en = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b1; redirect_addr = 19'h7FFFF; got = 0;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (instr_valid === 1'b1 && got < 3) begin seen[got] = instr_pc; got++; end
      @(negedge clk);
    end
    total++;
    if (got != 3) begin
      bad++; $display("[TB] FAIL wrap_count: got %0d want 3", got);
    end else begin
      total++;
      if (seen[0] !== 19'h7FFFF || seen[1] !== 19'h00000 || seen[2] !== 19'h00001) begin
        bad++; $display("[TB] FAIL wrap_seq: got %h %h %h want 7ffff 00000 00001", seen[0], seen[1], seen[2]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    int got;
    do_reset();
    en = 1'b1; instr_ready = 1'b0; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (queue_count === 3'd2) found = 1;
      else @(negedge clk);
    end
    total++;
    if (!found) begin bad++; $display("[TB] FAIL rmid_setup: got found=0 want 1"); end
    rst_n = 1'b0;
    #1;
    total++;
    if (im_rd_en !== 1'b0 || im_addr !== 19'd0 || instr_valid !== 1'b0 ||
        instr_data !== 19'd0 || instr_pc !== 19'd0 || queue_count !== 3'd0) begin
      bad++; $display("[TB] FAIL rmid_async: got rd=%b addr=%h v=%b d=%h pc=%h cnt=%0d want all 0",
                      im_rd_en, im_addr, instr_valid, instr_data, instr_pc, queue_count);
    end
    @(negedge clk);
    rst_n = 1'b1; instr_ready = 1'b1; exp_pc = '0; got = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (instr_valid === 1'b1) begin
        total++;
        if (instr_pc !== exp_pc || instr_data !== mem_word(exp_pc)) begin
          bad++; $display("[TB] FAIL rmid_word: got pc=%h want pc=%h", instr_pc, exp_pc);
        end
        exp_pc++; got++;
      end
      @(negedge clk);
    end
    total++;
    if (got == 0) begin bad++; $display("[TB] FAIL rmid_restart: got 0 words want >0"); end
  endtask

  task automatic test_redirect_pop_en0();
    bit found;
    int got, rd_seen;
    // Redirect and pop in the same cycle
    do_reset();
    en = 1'b1; instr_ready = 1'b0; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (queue_count === 3'd2) found = 1;
      else @(negedge clk);
    end
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_addr = 19'h00200;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    total++;
    if (queue_count !== 3'd0 || instr_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL rpop_count: got count=%0d valid=%b want 0 0", queue_count, instr_valid);
    end
    exp_pc = 19'h00200; got = 0;
    for (int i = 0; i < 8; i++) begin
      if (instr_valid === 1'b1) begin
        total++;
        if (instr_pc !== exp_pc) begin bad++; $display("[TB] FAIL rpop_word: got pc=%h want pc=%h", instr_pc, exp_pc); end
        exp_pc++; got++;
      end
      @(negedge clk); #1;
    end
    total++;
    if (got == 0) begin bad++; $display("[TB] FAIL rpop_progress: got 0 words want >0"); end
    @(negedge clk);

    // en dropped with one read in flight: the word still lands
    do_reset();
    en = 1'b1; instr_ready = 1'b0; found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      #1;
      if (im_rd_en === 1'b1) found = 1;
      @(negedge clk);
    end
    en = 1'b0; rd_seen = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (im_rd_en === 1'b1) rd_seen++;
      @(negedge clk);
    end
    #1;
    total += 2;
    if (rd_seen != 0) begin bad++; $display("[TB] FAIL en0_issue: got %0d reads want 0", rd_seen); end
    if (queue_count !== 3'd1 || instr_pc !== 19'd0 || instr_data !== mem_word(19'd0)) begin
      bad++; $display("[TB] FAIL en0_enqueue: got cnt=%0d pc=%h d=%h want 1 0 %h", queue_count, instr_pc, instr_data, mem_word(19'd0));
    end
    @(negedge clk);

    // en dropped and redirect while the read is in flight: the word is discarded
    do_reset();
    en = 1'b1; instr_ready = 1'b0; found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      #1;
      if (im_rd_en === 1'b1) found = 1;
      @(negedge clk);
    end
    en = 1'b0; redirect_valid = 1'b1; redirect_addr = 19'h00300;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    #1;
    total++;
    if (queue_count !== 3'd0 || instr_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL en0_redir_discard: got cnt=%0d valid=%b want 0 0", queue_count, instr_valid);
    end
    @(negedge clk);
    en = 1'b1; instr_ready = 1'b1; exp_pc = 19'h00300; got = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (instr_valid === 1'b1) begin
        total++;
        if (instr_pc !== exp_pc) begin bad++; $display("[TB] FAIL en0_redir_word: got pc=%h want pc=%h", instr_pc, exp_pc); end
        exp_pc++; got++;
      end
      @(negedge clk);
    end
    total++;
    if (got == 0) begin bad++; $display("[TB] FAIL en0_redir_progress: got 0 words want >0"); end
  endtask

  task automatic test_random();
    bit          hold;
    logic [18:0] hold_pc, hold_data;
    int          got;
    do_reset();
    exp_pc = '0; hold = 0; got = 0; hold_pc = '0; hold_data = '0;
    for (int i = 0; i < 400; i++) begin
      en             = ($urandom_range(0, 9) != 0);
      instr_ready    = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_addr  = ($urandom_range(0, 3) == 0) ? 19'h7FFFE : 19'($urandom);
      #1;
      total++;
      if (queue_count > 3'd4) begin bad++; $display("[TB] FAIL rnd_count: got %0d want <=4", queue_count); end
      if (hold) begin
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== hold_pc || instr_data !== hold_data) begin
          bad++; $display("[TB] FAIL rnd_stable: got v=%b pc=%h d=%h want 1 %h %h", instr_valid, instr_pc, instr_data, hold_pc, hold_data);
        end
      end
      if (redirect_valid) begin
        exp_pc = redirect_addr;
        hold = 0;
      end else begin
        if (instr_valid === 1'b1 && instr_ready) begin
          total++;
          if (instr_pc !== exp_pc || instr_data !== mem_word(exp_pc)) begin
            bad++; $display("[TB] FAIL rnd_word: got pc=%h data=%h want pc=%h data=%h", instr_pc, instr_data, exp_pc, mem_word(exp_pc));
          end
          exp_pc++; got++;
        end
        hold = (instr_valid === 1'b1) && !instr_ready;
        hold_pc = instr_pc; hold_data = instr_data;
      end
      @(negedge clk);
    end
    redirect_valid = 1'b0;
    total++;
    if (got < 50) begin bad++; $display("[TB] FAIL rnd_progress: got %0d words want >=50", got); end
  endtask

  initial begin
    $display("[TB] fetch_unit bench starting");
    test_reset();
    test_sequential();
    test_stall_fill();
    test_redirect();
    test_pc_wrap();
    test_reset_mid();
    test_redirect_pop_en0();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 19-bit CPU. It holds the program counter and drives read requests into instruction memory. It buffers the returned words in a small prefetch queue and hands them to the decode stage over a valid/ready handshake, tagged with their PC. Branch/jump redirects from execute flush the queue and restart fetch at the new address.

## Interface
- WORD_SIZE, 19: instruction width (from constants package).
- ADDR_WIDTH, 19: PC / instruction-memory address width.
- QUEUE_DEPTH, 4: prefetch queue entries; power of two, ≥ 2.
- RESET_PC, 0: PC value loaded at reset.

- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  fetch enable; 0 = stop issuing new reads (queue still drains).
- redirect_valid  in  1  one-cycle pulse: flush and restart at redirect_addr.
- redirect_addr  in  ADDR_WIDTH  new fetch address.
- im_rd_en  out  1  read request to instruction memory (drives RD_EN_IM).
- im_addr  out  ADDR_WIDTH  read address (drives the address bus).
- im_instr  in  WORD_SIZE  memory read data, valid the cycle after a request.
- instr_valid  out  1  queue head valid to decode.
- instr_ready  in  1  decode accepts head this cycle.
- instr_data  out  WORD_SIZE  head instruction.
- instr_pc  out  ADDR_WIDTH  address the head instruction was fetched from.
- queue_count  out  $clog2(QUEUE_DEPTH)+1  current occupancy.

## Operation
- Registers: pc, in-flight flag + in-flight pc tag, queue (data+pc per entry), head/tail pointers, count, FSM state.
- FSM states:
  - IDLE: en=0. No issue.
  - RUN: issuing.
  - STALL: en=1 but count + inflight == QUEUE_DEPTH.
- Transitions:
  - IDLE→RUN when en=1.
  - RUN→STALL on credit exhaustion.
  - STALL→RUN when a pop frees credit.
  - Any state→IDLE when en=0.
- Issue condition: en & !redirect_valid & (count + inflight < QUEUE_DEPTH).
- On issue: im_rd_en=1, im_addr=pc (combinational from pc register), then pc ← pc+1 mod 2^ADDR_WIDTH; set inflight, tag ← pc.
- When no issue: im_rd_en=0, im_addr=pc.
- Response: in the cycle after an issue, im_instr is written into the queue at tail with the tag, unless a flush occurred in between.
- Pop: instr_valid & instr_ready advances head.
- Push and pop in the same cycle: count unchanged.
- Credit rule guarantees no push into a full queue. Overflow cannot happen, and an assertion flags it if it does.
- Redirect (highest priority):
  - Queue emptied (count←0, head=tail).
  - In-flight response discarded.
  - pc ← redirect_addr.
  - No issue that cycle; a pop in the same cycle is ignored.
- instr_valid = (count != 0); instr_data/instr_pc = head entry. All three are stable while valid & !ready.
- PC wrap: 2^ADDR_WIDTH-1 → 0, no flag.

## Timing
- Reset values:
  - im_rd_en=0, im_addr=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0, queue_count=0.
  - pc=RESET_PC, inflight=0, state=IDLE.
- Reset mid-operation: everything cleared asynchronously; any pending memory response is ignored.
- First issue: first rising edge after rst_n high with en=1 (state IDLE→RUN that edge; im_rd_en high in the following cycle).
- Issue-to-valid latency: issue in cycle N, im_instr sampled end of cycle N+1, instr_valid=1 in cycle N+2.
- Throughput: one instruction/cycle sustained with instr_ready held high and QUEUE_DEPTH ≥ 2.
- Redirect in cycle R: first issue at redirect_addr in cycle R+1; first valid at R+3.
- en deasserted: in-flight read still completes and is enqueued.

## Test plan
- Memory holds 0x12340, 0x0ABCD, 0x05678, 0x1EFF0 at 0..3; reset then en=1, instr_ready=1 → decode receives those four words with pc 0,1,2,3 on consecutive cycles, first valid 3 cycles after en.
- instr_ready=0 with en=1 → exactly QUEUE_DEPTH (4) reads issued, queue_count=4, im_rd_en stays 0. Raise ready → words 0..3 in order, then fetch resumes at pc=4 without gaps or duplicates.
- Redirect to 0x00100 while queue holds 3 entries and one read is in flight → next valid instruction has instr_pc=0x00100; none of the stale 4 words ever appear.
- Redirect to 0x7FFFF → instr_pc sequence 0x7FFFF, 0x00000, 0x00001.
- rst_n pulsed low mid-stream with count=2 → all outputs at reset values immediately. After release, fetch restarts at RESET_PC=0.
- Redirect and pop in same cycle, and en=0 with one read in flight → redirect wins (count=0); the in-flight word is still enqueued under en=0 only when no redirect occurred.
